irq_seq: RTL and testbench
==========================

# irq_seq

Interrupt entry/exit sequencer between `irq_ctrl` and the CPU core. When `irq_ctrl` asserts take, this block stalls the core and pushes the return PC and a flags word to a memory stack. It then redirects the PC to the interrupt vector. On RETI it pops both words, restores PC, flags and IE, and pulses the return strobe back to `irq_ctrl`. It also owns the global interrupt-enable bit and nesting depth, and drives `irq_ctrl`'s `i_int_en`, `i_in_irq` and `i_irq_ret`.

## Interface
- STACK_TOP, 16'hFF00: reset value of the internal stack pointer; byte address, stack grows down.
- MAX_DEPTH, 2: maximum nesting depth; equals the `irq_ctrl` priority-stack depth.
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_irq_take  in  1  take strobe from `irq_ctrl`
- i_irq_vector  in  16  vector from `irq_ctrl`; valid with take
- i_reti  in  1  one-cycle pulse from core decode: RETI
- i_ei / i_di  in  1 / 1  one-cycle pulses: set / clear IE
- i_pc  in  16  return address; sampled with take
- i_flags  in  8  core flags; sampled with take
- o_int_en  out  1  to `irq_ctrl` i_int_en
- o_in_irq  out  1  depth != 0
- o_irq_ret  out  1  one-cycle return pulse to `irq_ctrl`
- o_stall  out  1  freeze core fetch/execute
- o_pc_load / o_pc_val  out  1 / 16  PC redirect pulse / value
- o_flags_load / o_flags_val  out  1 / 8  flags restore pulse / value
- o_fault  out  1  one-cycle pulse: RETI received at depth 0
- o_mem_req, o_mem_we  out  1 each  stack bus request, write
- o_mem_addr, o_mem_wdata  out  16 each  stack bus address, write data
- i_mem_rdy  in  1  request accepted/completed this cycle
- i_mem_rdata  in  16  read data; valid with rdy on reads

## Operation
- **States:** IDLE, PUSH_PC, PUSH_FL, VEC, POP_FL, POP_PC, RET.
- **Registers:** sp (16), depth (0..MAX_DEPTH), ie, reti_pend, and latched vec/pc/flw.
- **Flags word:** {ie, 7'b0, flags[7:0]}.
- **o_int_en** = ie & (state==IDLE) & (depth<MAX_DEPTH).
- **IDLE + take:**
  - Latch vector, pc and flags word.
  - sp_next = sp-2.
  - Go to PUSH_PC.
  - Take is only honoured when o_int_en=1.
- **PUSH_PC:**
  - req=1, we=1, addr=sp (already decremented), wdata=pc.
  - On rdy: sp-=2, go to PUSH_FL.
- **PUSH_FL:**
  - Write flw to sp.
  - On rdy: go to VEC.
- **VEC:**
  - o_pc_load=1, o_pc_val=vec.
  - depth+=1.
  - Go to IDLE.
  - IE unchanged; `irq_ctrl` handles preemption by priority.
- **IDLE + (i_reti or reti_pend), depth>0:**
  - Clear reti_pend.
  - Go to POP_FL.
- **POP_FL:**
  - req=1, we=0, addr=sp.
  - On rdy: capture rdata, sp+=2, go to POP_PC.
- **POP_PC:**
  - Read at sp.
  - On rdy: capture pc, sp+=2, go to RET.
- **RET:**
  - o_pc_load=1 with popped PC.
  - o_flags_load=1 with popped [7:0].
  - ie <= popped[15].
  - o_irq_ret=1.
  - depth-=1.
  - Go to IDLE.
- **RETI at depth 0:** o_fault pulse only; no state change.
- **Simultaneous take and reti in IDLE:** take wins; reti sets reti_pend, which is serviced on the next return to IDLE.
- **i_reti while not IDLE:** sets reti_pend.
- **i_ei / i_di:** effective only in IDLE and not in RET. If both are asserted, di wins. RET's restore overrides both.
- **sp arithmetic:** modulo 2^16, no overflow check. Depth bounding is enforced by o_int_en.

## Timing
- **Reset values:**
  - state=IDLE, sp=STACK_TOP, depth=0, ie=0, reti_pend=0.
  - All outputs 0, except o_mem_addr = STACK_TOP.
- **o_stall** = (state==IDLE & i_irq_take) | (state!=IDLE).
  - Combinational from take, so the core freezes in the take cycle.
- **Bus handshake:**
  - req, addr, we and wdata are held stable until rdy is sampled high.
  - A request completes in the rdy cycle; req drops or advances the next cycle.
  - rdy while req=0 is ignored.
- **Entry latency, zero-wait bus:** take at cycle T, PUSH_PC at T+1, PUSH_FL at T+2, o_pc_load at T+3. Each wait state adds 1 cycle.
- **Return latency, zero-wait bus:** reti at T, POP_FL at T+1, POP_PC at T+2, RET (pc_load + irq_ret) at T+3.
- **Reset mid-sequence:** the sequence is abandoned and req drops the next cycle. Stack contents are not cleaned.

## Structure
- **Shared package `irq_pkg`:**
  - State encoding localparams.
  - Flags-word bit positions (IE_BIT=15).
  - Stack word size (2).
  - Vector constants shared with `irq_ctrl`.
- **Single module, no sub-module.** The FSM, sp and depth counters are small enough to stay inline.

## Test plan
- **Entry:** ie=1, pc=16'h1234, flags=8'h5A, take with vector 16'h0040, zero-wait bus.
  - Writes 16'h1234 to 16'hFEFE, then 16'h805A to 16'hFEFC.
  - o_pc_val=16'h0040 at T+3.
  - depth=1, o_stall high for T..T+3.
- **Return:** RETI after the entry above.
  - Reads FEFC then FEFE.
  - RET cycle: pc=16'h1234, flags=8'h5A, ie=1, o_irq_ret=1.
  - sp back to 16'hFF00, depth=0.
- **Nesting limit:** two nested takes → depth=2 and o_int_en=0 while pending; a third take is not issued. Two RETIs then unwind in LIFO order.
- **Wait states:** rdy held low for 3 cycles during PUSH_PC → addr/wdata stable throughout; o_pc_load at T+6.
- **Collisions and fault:**
  - take and reti in the same IDLE cycle → entry completes, then the return sequence starts immediately from reti_pend.
  - reti at depth 0 → single o_fault pulse, no bus activity.
- **Reset mid-sequence:** reset asserted in PUSH_FL → IDLE, sp=16'hFF00, ie=0, req=0 the next cycle.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt entry/exit sequencer and irq_ctrl.
package irq_pkg;

    localparam logic [15:0] IRQ_STACK_TOP = 16'hFF00;
    localparam int          IRQ_MAX_DEPTH = 2;
    localparam int          IE_BIT        = 15;
    localparam logic [15:0] WORD_BYTES    = 16'd2;

    // Vector table layout shared with irq_ctrl.
    localparam logic [15:0] VEC_BASE      = 16'h0040;
    localparam logic [15:0] VEC_STRIDE    = 16'h0040;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PUSH_PC = 3'd1,
        S_PUSH_FL = 3'd2,
        S_VEC     = 3'd3,
        S_POP_FL  = 3'd4,
        S_POP_PC  = 3'd5,
        S_RET     = 3'd6
    } seq_state_e;

    // Saved status word: IE in bit IE_BIT, core flags in the low byte.
    function automatic logic [15:0] make_flags_word(input logic ie, input logic [7:0] flags);
        return {ie, 7'b0, flags};
    endfunction

endpackage

// File: rtl/irq_seq.sv
// Interrupt entry/exit sequencer: stacks PC and flags on entry, restores them on RETI,
// and owns the global interrupt enable and nesting depth.
module irq_seq
    import irq_pkg::*;
#(
    parameter logic [15:0] STACK_TOP = IRQ_STACK_TOP,
    parameter int          MAX_DEPTH = IRQ_MAX_DEPTH
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_irq_take,
    input  logic [15:0] i_irq_vector,
    input  logic        i_reti,
    input  logic        i_ei,
    input  logic        i_di,
    input  logic [15:0] i_pc,
    input  logic [7:0]  i_flags,
    output logic        o_int_en,
    output logic        o_in_irq,
    output logic        o_irq_ret,
    output logic        o_stall,
    output logic        o_pc_load,
    output logic [15:0] o_pc_val,
    output logic        o_flags_load,
    output logic [7:0]  o_flags_val,
    output logic        o_fault,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic        i_mem_rdy,
    input  logic [15:0] i_mem_rdata
);

    localparam int DW = $clog2(MAX_DEPTH + 1);

    seq_state_e    state_q, state_d;
    logic [15:0]   sp_q, sp_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          ie_q, ie_d;
    logic          pend_q, pend_d;
    logic [15:0]   vec_q, vec_d;
    logic [15:0]   pc_q, pc_d;
    logic [15:0]   flw_q, flw_d;
    logic [15:0]   ret_pc_q, ret_pc_d;
    logic [7:0]    ret_flags_q, ret_flags_d;
    logic          ret_ie_q, ret_ie_d;
    logic          int_en;

    assign int_en   = ie_q && (state_q == S_IDLE) && (depth_q < DW'(MAX_DEPTH));
    assign o_int_en = int_en;
    assign o_in_irq = (depth_q != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            sp_q        <= STACK_TOP;
            depth_q     <= '0;
            ie_q        <= 1'b0;
            pend_q      <= 1'b0;
            vec_q       <= '0;
            pc_q        <= '0;
            flw_q       <= '0;
            ret_pc_q    <= '0;
            ret_flags_q <= '0;
            ret_ie_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            depth_q     <= depth_d;
            ie_q        <= ie_d;
            pend_q      <= pend_d;
            vec_q       <= vec_d;
            pc_q        <= pc_d;
            flw_q       <= flw_d;
            ret_pc_q    <= ret_pc_d;
            ret_flags_q <= ret_flags_d;
            ret_ie_q    <= ret_ie_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sp_d         = sp_q;
        depth_d      = depth_q;
        ie_d         = ie_q;
        pend_d       = pend_q;
        vec_d        = vec_q;
        pc_d         = pc_q;
        flw_d        = flw_q;
        ret_pc_d     = ret_pc_q;
        ret_flags_d  = ret_flags_q;
        ret_ie_d     = ret_ie_q;
        o_irq_ret    = 1'b0;
        o_stall      = (state_q != S_IDLE) || i_irq_take;
        o_pc_load    = 1'b0;
        o_pc_val     = '0;
        o_flags_load = 1'b0;
        o_flags_val  = '0;
        o_fault      = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = sp_q;
        o_mem_wdata  = '0;

        // A RETI that arrives mid-sequence is remembered and serviced back in IDLE.
        if (i_reti && (state_q != S_IDLE)) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_di) begin
                    ie_d = 1'b0;
                end else if (i_ei) begin
                    ie_d = 1'b1;
                end
                if (i_irq_take && int_en) begin
                    vec_d   = i_irq_vector;
                    pc_d    = i_pc;
                    flw_d   = make_flags_word(ie_q, i_flags);
                    sp_d    = sp_q - WORD_BYTES;
                    state_d = S_PUSH_PC;
                    if (i_reti) begin
                        pend_d = 1'b1;
                    end
                end else if (i_reti || pend_q) begin
                    pend_d = 1'b0;
                    if (depth_q != '0) begin
                        state_d = S_POP_FL;
                    end else begin
                        o_fault = 1'b1;
                    end
                end
            end
            S_PUSH_PC: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_wdata = pc_q;
                if (i_mem_rdy) begin
                    sp_d    = sp_q - WORD_BYTES;
                    state_d = S_PUSH_FL;
                end
            end
            S_PUSH_FL: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_wdata = flw_q;
                if (i_mem_rdy) begin
                    state_d = S_VEC;
                end
            end
            S_VEC: begin
                o_pc_load = 1'b1;
                o_pc_val  = vec_q;
                depth_d   = depth_q + DW'(1);
                state_d   = S_IDLE;
            end
            S_POP_FL: begin
                o_mem_req = 1'b1;
                if (i_mem_rdy) begin
                    ret_flags_d = i_mem_rdata[7:0];
                    ret_ie_d    = i_mem_rdata[IE_BIT];
                    sp_d        = sp_q + WORD_BYTES;
                    state_d     = S_POP_PC;
                end
            end
            S_POP_PC: begin
                o_mem_req = 1'b1;
                if (i_mem_rdy) begin
                    ret_pc_d = i_mem_rdata;
                    sp_d     = sp_q + WORD_BYTES;
                    state_d  = S_RET;
                end
            end
            S_RET: begin
                o_pc_load    = 1'b1;
                o_pc_val     = ret_pc_q;
                o_flags_load = 1'b1;
                o_flags_val  = ret_flags_q;
                o_irq_ret    = 1'b1;
                ie_d         = ret_ie_q;
                depth_d      = depth_q - DW'(1);
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_seq.sv
// Directed bench for irq_seq: cycle table for entry/return/IE handling, then hand sequences.
module tb_irq_seq;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_irq_take;
    logic [15:0] i_irq_vector;
    logic        i_reti;
    logic        i_ei;
    logic        i_di;
    logic [15:0] i_pc;
    logic [7:0]  i_flags;
    logic        o_int_en;
    logic        o_in_irq;
    logic        o_irq_ret;
    logic        o_stall;
    logic        o_pc_load;
    logic [15:0] o_pc_val;
    logic        o_flags_load;
    logic [7:0]  o_flags_val;
    logic        o_fault;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic        i_mem_rdy;
    logic [15:0] i_mem_rdata;

    irq_seq dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_irq_take(i_irq_take), .i_irq_vector(i_irq_vector),
        .i_reti(i_reti), .i_ei(i_ei), .i_di(i_di),
        .i_pc(i_pc), .i_flags(i_flags),
        .o_int_en(o_int_en), .o_in_irq(o_in_irq), .o_irq_ret(o_irq_ret),
        .o_stall(o_stall), .o_pc_load(o_pc_load), .o_pc_val(o_pc_val),
        .o_flags_load(o_flags_load), .o_flags_val(o_flags_val), .o_fault(o_fault),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdy(i_mem_rdy), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        take;
        logic [15:0] vec;
        logic        reti, ei, di;
        logic [15:0] pc;
        logic [7:0]  flags;
        logic        rdy;
        logic [15:0] rdata;
    } ins_t;

    typedef struct packed {
        logic        stall, int_en, in_irq, irq_ret, fault, req, we;
        logic [15:0] addr, wdata;
        logic        pc_load;
        logic [15:0] pc_val;
        logic        flags_load;
        logic [7:0]  flags_val;
    } outs_t;

    typedef struct packed {
        ins_t  stim;
        outs_t expv;
    } row_t;

    row_t tbl[$];
    logic [15:0] mem [logic [15:0]];
    int n_checks = 0;
    int n_fail   = 0;
    int wait_cnt = 0;

    function automatic ins_t mk_in(logic take, logic [15:0] vec, logic reti, logic ei, logic di,
                                   logic [15:0] pc, logic [7:0] flags, logic rdy, logic [15:0] rdata);
        return '{take, vec, reti, ei, di, pc, flags, rdy, rdata};
    endfunction

    function automatic outs_t mk_out(logic stall, logic int_en, logic in_irq, logic irq_ret,
                                     logic fault, logic req, logic we, logic [15:0] addr,
                                     logic [15:0] wdata, logic pc_load, logic [15:0] pc_val,
                                     logic flags_load, logic [7:0] flags_val);
        return '{stall, int_en, in_irq, irq_ret, fault, req, we, addr, wdata,
                 pc_load, pc_val, flags_load, flags_val};
    endfunction

    // Fields that carry no meaning when their qualifier is low are excluded from the compare.
    function automatic outs_t mask(outs_t a, outs_t e);
        outs_t r = a;
        if (!e.req)        r.addr      = '0;
        if (!e.we)         r.wdata     = '0;
        if (!e.pc_load)    r.pc_val    = '0;
        if (!e.flags_load) r.flags_val = '0;
        return r;
    endfunction

    function automatic outs_t sample();
        return '{o_stall, o_int_en, o_in_irq, o_irq_ret, o_fault, o_mem_req, o_mem_we,
                 o_mem_addr, o_mem_wdata, o_pc_load, o_pc_val, o_flags_load, o_flags_val};
    endfunction

    function automatic logic [15:0] rd(logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'hDEAD;
    endfunction

    task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc_start();
        @(negedge i_clk);
        i_irq_take = 1'b0; i_irq_vector = '0; i_reti = 1'b0; i_ei = 1'b0; i_di = 1'b0;
        i_pc = '0; i_flags = '0; i_mem_rdy = 1'b0; i_mem_rdata = '0;
    endtask

    // Stack memory model with a programmable number of wait states on the next request.
    task automatic bus();
        i_mem_rdy = 1'b0;
        if (o_mem_req) begin
            if (wait_cnt > 0) begin
                wait_cnt--;
            end else begin
                i_mem_rdy = 1'b1;
                if (o_mem_we) mem[o_mem_addr] = o_mem_wdata;
                else          i_mem_rdata = rd(o_mem_addr);
            end
        end
    endtask

    task automatic cyc_eval();
        #1;
        bus();
        #1;
    endtask

    task automatic idle_cycle();
        cyc_start();
        cyc_eval();
    endtask

    task automatic take_irq(logic [15:0] vec, logic [15:0] pc, logic [7:0] flags);
        cyc_start();
        i_irq_take = 1'b1; i_irq_vector = vec; i_pc = pc; i_flags = flags;
        cyc_eval();
    endtask

    task automatic reti_cycle();
        cyc_start();
        i_reti = 1'b1;
        cyc_eval();
    endtask

    task automatic run_to_pcload(output int n, output logic [15:0] pcv, output logic [7:0] fl,
                                 output logic ret);
        n = -1; pcv = '0; fl = '0; ret = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            idle_cycle();
            if (o_pc_load) begin
                n = k; pcv = o_pc_val; fl = o_flags_val; ret = o_irq_ret;
                break;
            end
        end
        $display("pc_load after %0d cycles: pc=%h flags=%h irq_ret=%0b", n, pcv, fl, ret);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int vec_at, ret_at;
        logic [15:0] pcv, vec_val, ret_pc;
        logic [7:0]  fl, ret_fl;
        logic        ret;

        // Entry, IE drop at depth 1, return restoring IE (di in RET ignored), fault, ei/di.
        tbl.push_back('{mk_in(0,0,0,1,0,0,0,1,0),           mk_out(0,0,0,0,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{mk_in(1,16'h0040,0,0,0,16'h1234,8'h5A,1,0), mk_out(1,1,0,0,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,0,1,0),           mk_out(1,0,0,0,0,1,1,16'hFEFE,16'h1234,0,0,0,0)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,0,1,0),           mk_out(1,0,0,0,0,1,1,16'hFEFC,16'h805A,0,0,0,0)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,0,1,0),           mk_out(1,0,0,0,0,0,0,0,0,1,16'h0040,0,0)});
        tbl.push_back('{mk_in(0,0,0,0,1,0,0,1,0),           mk_out(0,1,1,0,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{mk_in(0,0,1,0,0,0,0,1,0),           mk_out(0,0,1,0,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,0,1,16'h805A),    mk_out(1,0,1,0,0,1,0,16'hFEFC,0,0,0,0,0)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,0,1,16'h1234),    mk_out(1,0,1,0,0,1,0,16'hFEFE,0,0,0,0,0)});
        tbl.push_back('{mk_in(0,0,0,0,1,0,0,1,0),           mk_out(1,0,1,1,0,0,0,0,0,1,16'h1234,1,8'h5A)});
        tbl.push_back('{mk_in(0,0,1,0,0,0,0,1,0),           mk_out(0,1,0,0,1,0,0,0,0,0,0,0,0)});
        tbl.push_back('{mk_in(0,0,0,0,1,0,0,1,0),           mk_out(0,1,0,0,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{mk_in(0,0,0,1,1,0,0,1,0),           mk_out(0,0,0,0,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{mk_in(0,0,0,1,0,0,0,1,0),           mk_out(0,0,0,0,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{mk_in(0,0,0,0,0,0,0,1,0),           mk_out(0,1,0,0,0,0,0,0,0,0,0,0,0)});

        i_rst = 1'b1;
        cyc_start();
        cyc_start();
        cyc_start();
        i_rst = 1'b0;
        #1;
        chk("reset", 80'(sample()), 80'(mk_out(0,0,0,0,0,0,0,16'hFF00,0,0,0,0,0)));
        #1;

        foreach (tbl[r]) begin
            cyc_start();
            i_irq_take = tbl[r].stim.take;  i_irq_vector = tbl[r].stim.vec;
            i_reti     = tbl[r].stim.reti;  i_ei = tbl[r].stim.ei;  i_di = tbl[r].stim.di;
            i_pc       = tbl[r].stim.pc;    i_flags = tbl[r].stim.flags;
            i_mem_rdy  = tbl[r].stim.rdy;   i_mem_rdata = tbl[r].stim.rdata;
            #1;
            chk($sformatf("row%0d", r), 80'(mask(sample(), tbl[r].expv)),
                80'(mask(tbl[r].expv, tbl[r].expv)));
            $display("row %0d: take=%0b reti=%0b stall=%0b req=%0b addr=%h pc_load=%0b pc_val=%h",
                     r, i_irq_take, i_reti, o_stall, o_mem_req, o_mem_addr, o_pc_load, o_pc_val);
        end
        idle_cycle();
        chk("sp_home", 80'(o_mem_addr), 80'(16'hFF00));

        // Two nested entries, third take refused, LIFO unwind.
        take_irq(16'h0100, 16'hAAAA, 8'h11);
        run_to_pcload(n, pcv, fl, ret);
        chk("nest1_vec", 80'({n, pcv}), 80'({32'd3, 16'h0100}));
        idle_cycle();
        chk("nest1_en", 80'({o_in_irq, o_int_en}), 80'(2'b11));
        take_irq(16'h0200, 16'hBBBB, 8'h22);
        run_to_pcload(n, pcv, fl, ret);
        chk("nest2_vec", 80'(pcv), 80'(16'h0200));
        idle_cycle();
        chk("nest_max", 80'({o_in_irq, o_int_en}), 80'(2'b10));
        take_irq(16'h0300, 16'hCCCC, 8'h33);
        idle_cycle();
        chk("third_ignored", 80'({o_mem_req, o_pc_load, o_stall}), 80'(3'b000));
        chk("stack_frames", 80'({rd(16'hFEFE), rd(16'hFEFC), rd(16'hFEFA), rd(16'hFEF8)}),
            80'({16'hAAAA, 16'h8011, 16'hBBBB, 16'h8022}));
        reti_cycle();
        run_to_pcload(n, pcv, fl, ret);
        chk("unwind1", 80'({n, pcv, fl, ret}), 80'({32'd3, 16'hBBBB, 8'h22, 1'b1}));
        reti_cycle();
        run_to_pcload(n, pcv, fl, ret);
        chk("unwind2", 80'({n, pcv, fl, ret}), 80'({32'd3, 16'hAAAA, 8'h11, 1'b1}));
        idle_cycle();
        chk("unwind_home", 80'({o_mem_addr, o_in_irq}), 80'({16'hFF00, 1'b0}));

        // Three wait states on the first push.
        wait_cnt = 3;
        take_irq(16'h0040, 16'h1234, 8'h5A);
        for (int k = 1; k <= 4; k++) begin
            idle_cycle();
            chk($sformatf("ws_hold%0d", k), 80'({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata}),
                80'({1'b1, 1'b1, 16'hFEFE, 16'h1234}));
        end
        run_to_pcload(n, pcv, fl, ret);
        chk("ws_latency", 80'({n + 4, pcv}), 80'({32'd6, 16'h0040}));

        // Take and RETI together at depth 1: entry first, then the pending return.
        cyc_start();
        i_irq_take = 1'b1; i_irq_vector = 16'h0080; i_pc = 16'h4321; i_flags = 8'h3C; i_reti = 1'b1;
        cyc_eval();
        chk("coll_int_en", 80'(o_int_en), 80'(1'b1));
        vec_at = -1; ret_at = -1; vec_val = '0; ret_pc = '0; ret_fl = '0;
        for (int k = 1; k <= 12; k++) begin
            idle_cycle();
            if (o_pc_load && !o_irq_ret && vec_at < 0) begin
                vec_at = k; vec_val = o_pc_val;
            end
            if (o_irq_ret && ret_at < 0) begin
                ret_at = k; ret_pc = o_pc_val; ret_fl = o_flags_val;
            end
        end
        $display("collision: vector at +%0d, return at +%0d", vec_at, ret_at);
        chk("coll_entry", 80'({vec_at, vec_val}), 80'({32'd3, 16'h0080}));
        chk("coll_return", 80'({ret_at, ret_pc, ret_fl}), 80'({32'd7, 16'h4321, 8'h3C}));
        chk("coll_frame", 80'({rd(16'hFEFA), rd(16'hFEF8)}), 80'({16'h4321, 16'h803C}));
        reti_cycle();
        run_to_pcload(n, pcv, fl, ret);
        chk("coll_unwind", 80'({pcv, fl, ret}), 80'({16'h1234, 8'h5A, 1'b1}));
        idle_cycle();
        chk("coll_home", 80'({o_mem_addr, o_in_irq}), 80'({16'hFF00, 1'b0}));

        // RETI at depth 0.
        reti_cycle();
        chk("fault_pulse", 80'({o_fault, o_mem_req}), 80'(2'b10));
        for (int k = 1; k <= 3; k++) begin
            idle_cycle();
            chk($sformatf("fault_quiet%0d", k), 80'({o_fault, o_mem_req, o_stall}), 80'(3'b000));
        end

        // Reset while pushing the flags word.
        take_irq(16'h0040, 16'h1111, 8'h01);
        idle_cycle();
        cyc_start();
        i_rst = 1'b1;
        cyc_eval();
        chk("rst_in_pushfl", 80'({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata}),
            80'({1'b1, 1'b1, 16'hFEFC, 16'h8001}));
        cyc_start();
        i_rst = 1'b0;
        cyc_eval();
        chk("rst_mid", 80'({o_mem_req, o_int_en, o_in_irq, o_stall, o_mem_addr}),
            80'({4'b0000, 16'hFF00}));
        idle_cycle();
        chk("rst_quiet", 80'({o_mem_req, o_pc_load}), 80'(2'b00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
